tx_stream_scheduler: RTL

TX_STREAM_SCHEDULER -- requirements
Module: tx_stream_scheduler

---
 rtl/tx_sched_pkg.sv | 6 +
 rtl/skp_timer.sv | 17 +
 rtl/tx_stream_scheduler.sv | 83 ++++++++
 3 files changed

// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: scheduler state encoding and the K-character constants for the SKP ordered set
package tx_sched_pkg;
  typedef enum logic [1:0] {IDLE, DATA, OS, SKP} state_t;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
endpackage

// File: rtl/skp_timer.sv
// skp_timer: saturating count of output handshakes; pending once INTERVAL is reached, clear restarts (ports: clk_i, rst_i, tick, clear -> pending)
module skp_timer #(
  parameter int INTERVAL = 1180
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick,
  input  logic clear,
  output logic pending
);
  localparam int W = $clog2(INTERVAL + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i)
    if (rst_i || clear) cnt <= '0;
    else if (tick && !pending) cnt <= cnt + 1'b1;
  assign pending = cnt == W'(INTERVAL);
endmodule

// File: rtl/tx_stream_scheduler.sv
// tx_stream_scheduler: merges data and ordered-set streams into one registered symbol stream, inserting SKP ordered sets when TX_SKP_INSERT_EN is defined (ports: clk_i/rst_i, link_en_i, data_* in, os_* in, out_* to the lane controller)
module tx_stream_scheduler
  import tx_sched_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       link_en_i,
  input  logic [7:0] data_sym_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  input  logic [7:0] os_sym_i,
  input  logic       os_k_i,
  input  logic       os_valid_i,
  input  logic       os_last_i,
  output logic       os_ready_o,
  output logic [7:0] out_sym_o,
  output logic       out_k_o,
  output logic       out_is_os_o,
  output logic       out_bypass_scr_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);
  state_t state, state_nx;
  logic load_ok, data_go, os_go, skp_go, skp_done, skp_first, skp_pending, load;
  logic [7:0] sym_nx;
  assign load_ok = out_ready_i | ~out_valid_o;
  assign data_ready_o = load_ok && state == DATA;
  assign os_ready_o = load_ok && state == OS;
  assign data_go = data_ready_o & data_valid_i;
  assign os_go = os_ready_o & os_valid_i;
`ifdef TX_SKP_INSERT_EN
  logic [1:0] skp_idx;
  assign skp_go = load_ok && state == SKP;
  assign skp_done = skp_go && skp_idx == 2'd3;
  assign skp_first = skp_idx == 2'd0;
  always_ff @(posedge clk_i)
    if (rst_i || state != SKP) skp_idx <= '0;
    else if (skp_go) skp_idx <= skp_idx + 2'd1;
  skp_timer #(.INTERVAL(SKP_INTERVAL)) u_timer (
    .clk_i,
    .rst_i,
    .tick(out_valid_o && out_ready_i && link_en_i),
    .clear(state == IDLE && state_nx == SKP),
    .pending(skp_pending)
  );
`else
  logic skp_unused;
  assign skp_unused = SKP_INTERVAL != 0;
  assign skp_go = 1'b0;
  assign skp_done = 1'b1;
  assign skp_first = 1'b1;
  assign skp_pending = 1'b0;
`endif
  always_comb begin
    state_nx = (state == IDLE) ? (!(load_ok && link_en_i) ? IDLE : skp_pending ? SKP :
                                  os_valid_i ? OS : data_valid_i ? DATA : IDLE)
             : (state == DATA) ? (data_go && data_last_i ? IDLE : DATA)
             : (state == OS) ? (os_go && os_last_i ? IDLE : OS)
             : (skp_done ? IDLE : SKP);
  end
  assign load = data_go | os_go | skp_go;
  assign sym_nx = data_go ? data_sym_i : os_go ? os_sym_i : skp_first ? K_COM : K_SKP;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      out_valid_o <= 1'b0;
      out_sym_o <= '0;
      out_k_o <= 1'b0;
      out_is_os_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        out_valid_o <= 1'b1;
        out_sym_o <= sym_nx;
        out_k_o <= os_go ? os_k_i : !data_go;
        out_is_os_o <= !data_go;
      end else if (load_ok) out_valid_o <= 1'b0;
    end
  assign out_bypass_scr_o = out_is_os_o;
endmodule
